digit_scan_scheduler: RTL and testbench



---
 rtl/digit_scan_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_digit_scan_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_scheduler.sv
// -----------------------------------------------------------------------------
// digit_scan_scheduler
//
// Time-multiplexes one display-data path across NUM_DIGITS digits. Each digit
// is driven for DWELL_CYCLES clocks, then every select is released for
// BLANK_CYCLES clocks before the next digit. Frames arrive over a valid/ready
// handshake into a pending buffer. The pending buffer is copied to the active
// buffer only at a frame boundary, so a scan always shows one consistent frame.
//
// Optional feature (compile-time macro): SCAN_DIMMING_EN
//   When defined, a free-running 3-bit PWM counter gates sel_n during SHOW.
//   The digit is lit only while pwm_cnt <= brightness. When the macro is not
//   defined, brightness is ignored.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   scan enable; dropping it returns to IDLE on the next clock
//   frame_data   in   NUM_DIGITS*DATA_WIDTH, digit i at [i*DATA_WIDTH +: DATA_WIDTH]
//   frame_valid  in   frame_data valid
//   frame_ready  out  pending buffer is free (registered)
//   brightness   in   3-bit dimming level (SCAN_DIMMING_EN only)
//   sel_code     out  index of the digit being scanned
//   sel_n        out  active-low one-hot digit select
//   digit_data   out  data for the current digit
//   frame_done   out  one-cycle pulse when the scan wraps back to digit 0
// -----------------------------------------------------------------------------
module digit_scan_scheduler #(
  parameter int SEL_WIDTH    = 3,
  parameter int NUM_DIGITS   = 2**SEL_WIDTH,
  parameter int DATA_WIDTH   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [NUM_DIGITS*DATA_WIDTH-1:0] frame_data,
  input  logic                             frame_valid,
  output logic                             frame_ready,
  input  logic [2:0]                       brightness,
  output logic [SEL_WIDTH-1:0]             sel_code,
  output logic [NUM_DIGITS-1:0]            sel_n,
  output logic [DATA_WIDTH-1:0]            digit_data,
  output logic                             frame_done
);

  localparam int FRAME_W = NUM_DIGITS * DATA_WIDTH;

  // The single counter times both the dwell and the blank, so it is sized
  // for whichever of the two is longer. It counts down to zero.
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [SEL_WIDTH-1:0] LAST_CODE = SEL_WIDTH'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_W-1:0]   active_buf;
  logic [FRAME_W-1:0]   pending_buf;

  logic                 pending_full;
  logic                 take_frame;
  logic                 wrap;
  logic [SEL_WIDTH-1:0] next_code;
  logic                 step;
  logic                 boundary;
  logic [FRAME_W-1:0]   boundary_frame;
  logic                 show_on;

  // Active-low one-hot select for a digit index, or all-off when gated.
  function automatic logic [NUM_DIGITS-1:0] select_mask(
    input logic [SEL_WIDTH-1:0] code,
    input logic                 on
  );
    logic [NUM_DIGITS-1:0] m;
    m = '1;
    if (on) m[code] = 1'b0;
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] digit_slice(
    input logic [FRAME_W-1:0]   frame,
    input logic [SEL_WIDTH-1:0] code
  );
    return frame[int'(code)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // frame_ready is the registered copy; the pending-full flag is its inverse,
  // so the two can never disagree.
  assign pending_full = ~frame_ready;
  assign take_frame   = frame_valid & frame_ready;

`ifdef SCAN_DIMMING_EN
  logic [2:0] pwm_cnt;
  logic [2:0] pwm_next;

  assign pwm_next = pwm_cnt + 3'd1;

  // sel_n is registered, so the gate uses the PWM value for the cycle
  // being loaded, not the current one.
  assign show_on = (pwm_next <= brightness);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 3'd0;
    end else begin
      pwm_cnt <= pwm_next;
    end
  end
`else
  logic unused_brightness;

  assign unused_brightness = ^brightness;
  assign show_on           = 1'b1;
`endif

  // step: this cycle ends the current digit period and moves to the next
  // digit (from BLANK, or straight from SHOW when there is no blank gap).
  // boundary: the next digit is digit 0 of a new frame, so the pending
  // buffer is swapped in if it holds a frame.
  always_comb begin
    wrap           = (sel_code == LAST_CODE);
    next_code      = wrap ? '0 : sel_code + 1'b1;
    step           = 1'b0;
    boundary       = 1'b0;
    boundary_frame = pending_full ? pending_buf : active_buf;
    if (cnt == '0) begin
      if (state == BLANK) step = 1'b1;
      if (state == SHOW && BLANK_CYCLES == 0) step = 1'b1;
    end
    if (enable) begin
      if (state == IDLE) boundary = 1'b1;
      if (step && wrap) boundary = 1'b1;
    end
  end

  // Scan state machine, handshake and buffers, all registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_code    <= '0;
      sel_n       <= '1;
      digit_data  <= '0;
      frame_done  <= 1'b0;
      frame_ready <= 1'b1;
      active_buf  <= '0;
      pending_buf <= '0;
    end else begin
      frame_done <= 1'b0;

      if (take_frame) begin
        pending_buf <= frame_data;
        frame_ready <= 1'b0;
      end

      // A handshake can only complete while pending is empty, so it never
      // collides with the swap below. A frame captured in a boundary cycle
      // therefore waits for the next boundary.
      if (boundary && pending_full) begin
        active_buf  <= pending_buf;
        frame_ready <= 1'b1;
      end

      if (!enable) begin
        state    <= IDLE;
        cnt      <= '0;
        sel_code <= '0;
        sel_n    <= '1;
      end else begin
        case (state)
          IDLE: begin
            state      <= SHOW;
            cnt        <= DWELL_LOAD;
            sel_code   <= '0;
            sel_n      <= select_mask('0, show_on);
            digit_data <= digit_slice(boundary_frame, '0);
          end

          SHOW: begin
            if (cnt != '0) begin
              cnt   <= cnt - 1'b1;
              sel_n <= select_mask(sel_code, show_on);
            end else if (BLANK_CYCLES > 0) begin
              state <= BLANK;
              cnt   <= BLANK_LOAD;
              sel_n <= '1;
            end
          end

          BLANK: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
            sel_n <= '1;
          end
        endcase

        if (step) begin
          state      <= SHOW;
          cnt        <= DWELL_LOAD;
          sel_code   <= next_code;
          sel_n      <= select_mask(next_code, show_on);
          digit_data <= digit_slice(wrap ? boundary_frame : active_buf, next_code);
          frame_done <= wrap;
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_scheduler.sv
// -----------------------------------------------------------------------------
// tb_digit_scan_scheduler
//
// Directed, self-checking bench for digit_scan_scheduler with SEL_WIDTH=3,
// DATA_WIDTH=4, DWELL_CYCLES=4, BLANK_CYCLES=1 (a 5-cycle digit period and a
// 40-cycle frame). Expected values come from hand-written frame tables and
// the index arithmetic of the scan.
// -----------------------------------------------------------------------------
module tb_digit_scan_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  brightness;
  logic [2:0]  sel_code;
  logic [7:0]  sel_n;
  logic [3:0]  digit_data;
  logic        frame_done;

  int tests;
  int fails;

  // Frame shown during each 40-cycle scan of the long run.
  logic [31:0] frames [4];

  digit_scan_scheduler #(
    .SEL_WIDTH   (3),
    .NUM_DIGITS  (8),
    .DATA_WIDTH  (4),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .brightness (brightness),
    .sel_code   (sel_code),
    .sel_n      (sel_n),
    .digit_data (digit_data),
    .frame_done (frame_done)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all handshake/control inputs at once.
  task automatic applyStimulus(
    input logic        en,
    input logic        valid,
    input logic [31:0] data,
    input logic [2:0]  bright
  );
    enable      = en;
    frame_valid = valid;
    frame_data  = data;
    brightness  = bright;
  endtask

  // Advance one clock and settle 1 ns past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(
    input string       tag,
    input logic [31:0] observed,
    input logic [31:0] expected
  );
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int          d;
    int          p;
    int          f;
    int          lows;
    logic [31:0] fr;
    logic [7:0]  exp_sel;
    logic        exp_ready;

    tests     = 0;
    fails     = 0;
    frames[0] = 32'h76543210;
    frames[1] = 32'hFFFFFFFF;
    frames[2] = 32'hFFFFFFFF;
    frames[3] = 32'hAAAAAAA5;

    // Power-on reset with every input quiet.
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 3'd7);
    #12;
    checkOutput("reset_sel_n",       32'(sel_n),       32'hFF);
    checkOutput("reset_sel_code",    32'(sel_code),    32'h0);
    checkOutput("reset_digit_data",  32'(digit_data),  32'h0);
    checkOutput("reset_frame_done",  32'(frame_done),  32'h0);
    checkOutput("reset_frame_ready", 32'(frame_ready), 32'h1);
    rst_n = 1'b1;

    // Load the first frame while IDLE; pending fills and ready drops.
    applyStimulus(1'b0, 1'b1, frames[0], 3'd7);
    tick();
    checkOutput("idle_load_ready", 32'(frame_ready), 32'h0);
    checkOutput("idle_sel_n",      32'(sel_n),       32'hFF);

    // Start scanning. k counts cycles from SHOW entry. A second frame is
    // offered at digit 3 of scan 0 and a third lands exactly on the wrap
    // edge into scan 2, so it is only displayed from scan 3.
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd7);
    tick();
    for (int k = 0; k <= 149; k++) begin
      d         = (k % 40) / 5;
      p         = k % 5;
      f         = k / 40;
      fr        = frames[f];
      exp_sel   = (p < 4) ? ~(8'h01 << d) : 8'hFF;
      exp_ready = (k <= 15) || (k >= 40 && k <= 79) || (k >= 120);
      checkOutput($sformatf("scan_sel_n_k%0d", k),       32'(sel_n),       32'(exp_sel));
      checkOutput($sformatf("scan_sel_code_k%0d", k),    32'(sel_code),    32'(d));
      checkOutput($sformatf("scan_digit_data_k%0d", k),  32'(digit_data),  32'(fr[d*4 +: 4]));
      checkOutput($sformatf("scan_frame_done_k%0d", k),  32'(frame_done),  32'((k % 40 == 0) && (k > 0)));
      checkOutput($sformatf("scan_frame_ready_k%0d", k), 32'(frame_ready), 32'(exp_ready));
      if (k == 15)      applyStimulus(1'b1, 1'b1, frames[1], 3'd7);
      else if (k == 79) applyStimulus(1'b1, 1'b1, frames[3], 3'd7);
      else if (k < 149) applyStimulus(1'b1, 1'b0, 32'h0, 3'd7);
      if (k < 149) tick();
    end

    // k=149 is the blank slot of digit 5: drop enable there.
    applyStimulus(1'b0, 1'b0, 32'h0, 3'd7);
    tick();
    checkOutput("drop_sel_n",      32'(sel_n),      32'hFF);
    checkOutput("drop_sel_code",   32'(sel_code),   32'h0);
    checkOutput("drop_frame_done", 32'(frame_done), 32'h0);
    tick();
    checkOutput("idle_hold_sel_n",      32'(sel_n),      32'hFF);
    checkOutput("idle_hold_frame_done", 32'(frame_done), 32'h0);

    // Re-enable with brightness=1: the scan restarts at digit 0 of the
    // frame made active at the last wrap.
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd1);
    tick();
    checkOutput("reen_sel_code",   32'(sel_code),   32'h0);
    checkOutput("reen_digit_data", 32'(digit_data), 32'h5);
    checkOutput("reen_frame_done", 32'(frame_done), 32'h0);
    lows = 0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      if (sel_n != 8'hFF) lows++;
`ifndef SCAN_DIMMING_EN
      checkOutput($sformatf("dwell_sel_n_j%0d", j), 32'(sel_n), 32'hFE);
`endif
    end
`ifdef SCAN_DIMMING_EN
    checkOutput("dim_low_cycles_le2", 32'(lows <= 2), 32'h1);
`else
    checkOutput("dwell_low_cycles", 32'(lows), 32'h4);
`endif
    tick();
    checkOutput("dwell_blank_sel_n", 32'(sel_n), 32'hFF);

    // Into digit 1, then park a frame in pending.
    tick();
    checkOutput("d1_sel_code", 32'(sel_code), 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h12345678, 3'd7);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd7);
    checkOutput("pend_ready", 32'(frame_ready), 32'h0);
    checkOutput("pend_sel_n", 32'(sel_n),       32'hFD);

    // Asynchronous reset mid-SHOW, sampled before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_sel_n",       32'(sel_n),       32'hFF);
    checkOutput("async_sel_code",    32'(sel_code),    32'h0);
    checkOutput("async_frame_ready", 32'(frame_ready), 32'h1);
    checkOutput("async_digit_data",  32'(digit_data),  32'h0);
    checkOutput("async_frame_done",  32'(frame_done),  32'h0);
    rst_n = 1'b1;

    // Pending data was discarded by reset, so digit 0 shows the cleared frame.
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd7);
    tick();
    checkOutput("post_reset_sel_n",       32'(sel_n),       32'hFE);
    checkOutput("post_reset_digit_data",  32'(digit_data),  32'h0);
    checkOutput("post_reset_frame_ready", 32'(frame_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
